// File: rtl/riscv_core_pkg.sv
// Shared core types plus the write-back arbitration constants.
//   reg_addr_t / word_t : register address and data word
//   N_WB_REQ, WB_*      : number of write-back requesters and their port indices
//   wb_req_t            : one requester's {valid, rd, data} bundle
package riscv_core_pkg;

  typedef logic [4:0]  reg_addr_t;
  typedef logic [31:0] word_t;

  localparam int N_WB_REQ = 3;
  localparam int WB_ALU   = 0;
  localparam int WB_LSU   = 1;
  localparam int WB_MDU   = 2;

  typedef struct packed {
    logic      valid;
    reg_addr_t rd;
    word_t     data;
  } wb_req_t;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter. Searches upward from ptr_i (mod N)
// and grants the first active request.
//   req_i     : request vector
//   ptr_i     : highest-priority index this cycle
//   gnt_o     : one-hot grant, zero when no request is active
//   gnt_idx_o : index of the granted request (0 when none)
module rr_arbiter #(
  parameter int N     = 3,
  parameter int PTR_W = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]     req_i,
  input  logic [PTR_W-1:0] ptr_i,
  output logic [N-1:0]     gnt_o,
  output logic [PTR_W-1:0] gnt_idx_o
);

  logic found;

  // NOTE: every output of a combinational block gets a default before any
  // conditional assignment, otherwise synthesis infers a latch.
  always_comb begin
    gnt_o     = '0;
    gnt_idx_o = '0;
    found     = 1'b0;
    for (int i = 0; i < N; i++) begin
      int j;
      j = int'(ptr_i) + i;
      if (j >= N) j = j - N;
      if (!found && req_i[j]) begin
        found     = 1'b1;
        gnt_o[j]  = 1'b1;
        gnt_idx_o = PTR_W'(j);
      end
    end
  end

endmodule

// File: rtl/rf_wb_arbiter.sv
// Shares the single register-file write port among N_REQ write-back
// requesters. Round-robin grant, one accept per cycle, one-deep write stage,
// x0 writes absorbed, staged write bypassed onto both decode read ports.
//   req_valid_i/req_rd_addr_i/req_data_i : per-requester write (flattened)
//   req_ready_o                          : one-hot grant
//   rf_write_en_o/rf_rd_addr_o/rf_rd_data_o : staged register-file write
//   rs*_addr_i, rf_rs*_data_i            : decode read address / raw RF data
//   rs*_data_o                           : bypassed read data
//   busy_o                               : staged write pending
module rf_wb_arbiter
  import riscv_core_pkg::*;
#(
  parameter int N_REQ = N_WB_REQ,
  parameter int PTR_W = $clog2(N_REQ)
) (
  input  logic               clk_i,
  input  logic               rst_ni,
  input  logic [N_REQ-1:0]   req_valid_i,
  input  logic [N_REQ*5-1:0] req_rd_addr_i,
  input  logic [N_REQ*32-1:0] req_data_i,
  output logic [N_REQ-1:0]   req_ready_o,
  output logic               rf_write_en_o,
  output logic [4:0]         rf_rd_addr_o,
  output logic [31:0]        rf_rd_data_o,
  input  logic [4:0]         rs1_addr_i,
  input  logic [4:0]         rs2_addr_i,
  input  logic [31:0]        rf_rs1_data_i,
  input  logic [31:0]        rf_rs2_data_i,
  output logic [31:0]        rs1_data_o,
  output logic [31:0]        rs2_data_o,
  output logic               busy_o
);

  wb_req_t          reqs [N_REQ];
  wb_req_t          sel;
  logic [N_REQ-1:0] gnt;
  logic [PTR_W-1:0] gnt_idx;
  logic [PTR_W-1:0] ptr_q;
  logic             accept;

  logic             stage_valid_q;
  reg_addr_t        stage_rd_q;
  word_t            stage_data_q;

  always_comb begin
    for (int i = 0; i < N_REQ; i++) begin
      reqs[i] = '{valid: req_valid_i[i],
                  rd:    req_rd_addr_i[i*5 +: 5],
                  data:  req_data_i[i*32 +: 32]};
    end
  end

  rr_arbiter #(.N(N_REQ), .PTR_W(PTR_W)) u_rr (
    .req_i     (req_valid_i),
    .ptr_i     (ptr_q),
    .gnt_o     (gnt),
    .gnt_idx_o (gnt_idx)
  );

  // Nothing is accepted while reset is held, so in-flight requests wait.
  assign req_ready_o = rst_ni ? gnt : '0;
  assign accept      = |req_ready_o;
  assign sel         = reqs[gnt_idx];

  // NOTE: sequential state uses non-blocking assignments with an asynchronous
  // active-low reset in the sensitivity list.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      ptr_q <= '0;
    end else if (accept) begin
      ptr_q <= (gnt_idx == PTR_W'(N_REQ - 1)) ? '0 : gnt_idx + PTR_W'(1);
    end
  end

  // An x0 accept clears the stage but keeps the last address/data, so a
  // write to x0 can never appear on the port.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      stage_valid_q <= 1'b0;
      stage_rd_q    <= '0;
      stage_data_q  <= '0;
    end else begin
      stage_valid_q <= accept && (sel.rd != '0);
      if (accept && (sel.rd != '0)) begin
        stage_rd_q   <= sel.rd;
        stage_data_q <= sel.data;
      end
    end
  end

  assign rf_write_en_o = stage_valid_q;
  assign rf_rd_addr_o  = stage_rd_q;
  assign rf_rd_data_o  = stage_data_q;
  assign busy_o        = stage_valid_q;

  // The register file returns old data on a same-cycle read/write collision,
  // so the staged write is forwarded here.
  function automatic word_t bypass(reg_addr_t addr, word_t rf_data);
    if (addr == '0)                                  return '0;
    else if (stage_valid_q && (addr == stage_rd_q))  return stage_data_q;
    else                                             return rf_data;
  endfunction

  assign rs1_data_o = bypass(rs1_addr_i, rf_rs1_data_i);
  assign rs2_data_o = bypass(rs2_addr_i, rf_rs2_data_i);

`ifndef SYNTHESIS
  a_grant_onehot0 : assert property (@(posedge clk_i) disable iff (!rst_ni)
    $onehot0(req_ready_o));

  a_no_x0_write : assert property (@(posedge clk_i) disable iff (!rst_ni)
    rf_write_en_o |-> (rf_rd_addr_o != '0));

  for (genvar g = 0; g < N_REQ; g++) begin : g_hold
    a_req_stable : assert property (@(posedge clk_i) disable iff (!rst_ni)
      (req_valid_i[g] && !req_ready_o[g]) |=>
        (req_valid_i[g] && $stable(req_rd_addr_i[g*5 +: 5])
                        && $stable(req_data_i[g*32 +: 32])));
  end
`endif

endmodule

// File: tb/tb_rf_wb_arbiter.sv
module tb_rf_wb_arbiter;

  localparam int N = 3;

  logic          clk_i = 1'b0;
  logic          rst_ni = 1'b0;
  logic [N-1:0]  valid;
  logic [4:0]    rd  [N];
  logic [31:0]   dat [N];
  logic [N*5-1:0]  req_rd_addr;
  logic [N*32-1:0] req_data;
  logic [N-1:0]  req_ready_o;
  logic          rf_write_en_o;
  logic [4:0]    rf_rd_addr_o;
  logic [31:0]   rf_rd_data_o;
  logic [4:0]    rs1_addr, rs2_addr;
  logic [31:0]   rf_rs1_data, rf_rs2_data;
  logic [31:0]   rs1_data_o, rs2_data_o;
  logic          busy_o;

  typedef struct packed {
    logic [4:0]  a;
    logic [31:0] d;
  } exp_t;

  exp_t exp_q [$];
  int   compared   = 0;
  int   mismatched = 0;

  always #5 clk_i = ~clk_i;

  always_comb begin
    for (int i = 0; i < N; i++) begin
      req_rd_addr[i*5 +: 5]  = rd[i];
      req_data[i*32 +: 32]   = dat[i];
    end
  end

  rf_wb_arbiter #(.N_REQ(N)) dut (
    .clk_i         (clk_i),
    .rst_ni        (rst_ni),
    .req_valid_i   (valid),
    .req_rd_addr_i (req_rd_addr),
    .req_data_i    (req_data),
    .req_ready_o   (req_ready_o),
    .rf_write_en_o (rf_write_en_o),
    .rf_rd_addr_o  (rf_rd_addr_o),
    .rf_rd_data_o  (rf_rd_data_o),
    .rs1_addr_i    (rs1_addr),
    .rs2_addr_i    (rs2_addr),
    .rf_rs1_data_i (rf_rs1_data),
    .rf_rs2_data_i (rf_rs2_data),
    .rs1_data_o    (rs1_data_o),
    .rs2_data_o    (rs2_data_o),
    .busy_o        (busy_o)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  // Monitor: every write on the port must match the oldest expected write.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk_i);
      if (rf_write_en_o) begin
        compared++;
        if (exp_q.size() == 0) begin
          mismatched++;
          $display("FAIL unexpected_write: got x%0d=0x%08h expected no write",
                   rf_rd_addr_o, rf_rd_data_o);
        end else begin
          e = exp_q.pop_front();
          if (rf_rd_addr_o !== e.a || rf_rd_data_o !== e.d) begin
            mismatched++;
            $display("FAIL write: got x%0d=0x%08h expected x%0d=0x%08h",
                     rf_rd_addr_o, rf_rd_data_o, e.a, e.d);
          end
        end
      end
    end
  end

  task automatic next_cycle();
    @(negedge clk_i);
    #1;
  endtask

  task automatic set_req(input int i, input logic v, input logic [4:0] a, input logic [31:0] d);
    valid[i] = v;
    rd[i]    = a;
    dat[i]   = d;
  endtask

  task automatic expect_write(input logic [4:0] a, input logic [31:0] d);
    if (a != 5'd0) exp_q.push_back('{a: a, d: d});
  endtask

  task automatic do_reset();
    next_cycle();
    rst_ni = 1'b0;
    next_cycle();
    rst_ni = 1'b1;
  endtask

  initial begin
    valid = '0;
    for (int i = 0; i < N; i++) begin rd[i] = '0; dat[i] = '0; end
    rs1_addr = '0; rs2_addr = '0; rf_rs1_data = '0; rf_rs2_data = '0;

    // Reset state
    repeat (2) next_cycle();
    check("rst_en",    32'(rf_write_en_o), 32'd0);
    check("rst_addr",  32'(rf_rd_addr_o),  32'd0);
    check("rst_data",  rf_rd_data_o,       32'd0);
    check("rst_busy",  32'(busy_o),        32'd0);
    rst_ni = 1'b1;
    next_cycle();
    check("idle_ready", 32'(req_ready_o),  32'd0);

    // 1: ALU writes x5
    set_req(0, 1'b1, 5'd5, 32'hDEADBEEF);
    #1 check("t1_ready", 32'(req_ready_o), 32'b001);
    expect_write(5'd5, 32'hDEADBEEF);
    next_cycle();
    set_req(0, 1'b0, 5'd0, 32'd0);
    check("t1_en_t1", 32'(rf_write_en_o), 32'd1);
    next_cycle();
    check("t1_en_t2", 32'(rf_write_en_o), 32'd0);

    // 2: all three requesters, pointer from 0
    do_reset();
    next_cycle();
    for (int i = 0; i < N; i++) set_req(i, 1'b1, 5'(i + 1), 32'h100 + 32'(i));
    #1 check("t2_gnt0", 32'(req_ready_o), 32'b001);
    expect_write(5'd1, 32'h100);
    next_cycle();
    set_req(0, 1'b0, 5'd0, 32'd0);
    #1 check("t2_gnt1", 32'(req_ready_o), 32'b010);
    expect_write(5'd2, 32'h101);
    next_cycle();
    set_req(1, 1'b0, 5'd0, 32'd0);
    #1 check("t2_gnt2", 32'(req_ready_o), 32'b100);
    expect_write(5'd3, 32'h102);
    next_cycle();
    set_req(2, 1'b0, 5'd0, 32'd0);
    next_cycle();

    // 3: LSU writes x0 -- absorbed, pointer moves to 2
    set_req(1, 1'b1, 5'd0, 32'h1234);
    #1 check("t3_ready", 32'(req_ready_o), 32'b010);
    next_cycle();
    set_req(1, 1'b0, 5'd0, 32'd0);
    check("t3_no_en", 32'(rf_write_en_o), 32'd0);

    // 4: pointer at 2 -> MDU beats ALU; then bypass of staged x7
    next_cycle();
    set_req(0, 1'b1, 5'd4, 32'h44);
    set_req(2, 1'b1, 5'd7, 32'hA5A5A5A5);
    #1 check("t4_ptr2", 32'(req_ready_o), 32'b100);
    expect_write(5'd7, 32'hA5A5A5A5);
    next_cycle();
    set_req(2, 1'b0, 5'd0, 32'd0);
    rs1_addr = 5'd7; rs2_addr = 5'd7;
    rf_rs1_data = 32'h11111111; rf_rs2_data = 32'h11111111;
    #1 check("t4_alu_gnt", 32'(req_ready_o), 32'b001);
    expect_write(5'd4, 32'h44);
    check("t4_rs1_byp", rs1_data_o, 32'hA5A5A5A5);
    check("t4_rs2_byp", rs2_data_o, 32'hA5A5A5A5);
    rs1_addr = 5'd0;
    #1 check("t4_rs1_x0", rs1_data_o, 32'd0);
    check("t4_rs2_hold", rs2_data_o, 32'hA5A5A5A5);
    next_cycle();
    set_req(0, 1'b0, 5'd0, 32'd0);
    rs1_addr = 5'd7; rs2_addr = 5'd4;
    #1 check("t4_rs1_raw", rs1_data_o, 32'h11111111);
    check("t4_rs2_byp4", rs2_data_o, 32'h44);

    // 5: back-to-back x9 writes from MDU
    next_cycle();
    rs1_addr = 5'd9; rf_rs1_data = 32'd0;
    set_req(2, 1'b1, 5'd9, 32'd1);
    #1 check("t5_gnt_a", 32'(req_ready_o), 32'b100);
    expect_write(5'd9, 32'd1);
    next_cycle();
    set_req(2, 1'b1, 5'd9, 32'd2);
    #1 check("t5_gnt_b", 32'(req_ready_o), 32'b100);
    expect_write(5'd9, 32'd2);
    check("t5_rs1_t1", rs1_data_o, 32'd1);
    next_cycle();
    set_req(2, 1'b0, 5'd0, 32'd0);
    #1 check("t5_rs1_t2", rs1_data_o, 32'd2);

    // 6: reset while a write is staged
    next_cycle();
    set_req(0, 1'b1, 5'd10, 32'h77);
    #1 check("t6_gnt", 32'(req_ready_o), 32'b001);
    expect_write(5'd10, 32'h77);
    next_cycle();
    set_req(0, 1'b0, 5'd0, 32'd0);
    check("t6_en_pre", 32'(rf_write_en_o), 32'd1);
    #1 rst_ni = 1'b0;
    #1 check("t6_en_rst", 32'(rf_write_en_o), 32'd0);
    check("t6_busy_rst", 32'(busy_o), 32'd0);
    check("t6_addr_rst", 32'(rf_rd_addr_o), 32'd0);
    next_cycle();
    rst_ni = 1'b1;
    for (int c = 0; c < 3; c++) begin
      next_cycle();
      check("t6_idle_en", 32'(rf_write_en_o), 32'd0);
    end
    // Pointer back at 0: ALU wins over MDU
    set_req(0, 1'b1, 5'd11, 32'hB1);
    set_req(2, 1'b1, 5'd12, 32'hC2);
    #1 check("t6_ptr0", 32'(req_ready_o), 32'b001);
    expect_write(5'd11, 32'hB1);
    next_cycle();
    set_req(0, 1'b0, 5'd0, 32'd0);
    #1 check("t6_mdu", 32'(req_ready_o), 32'b100);
    expect_write(5'd12, 32'hC2);
    next_cycle();
    set_req(2, 1'b0, 5'd0, 32'd0);
    repeat (3) next_cycle();

    check("sb_drained", 32'(exp_q.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

  initial begin
    #20000;
    $display("FAIL timeout: got no end of test expected finish before 20000");
    $fatal(1, "timeout");
  end

endmodule
